// File: rtl/fft_modulus_frame_ctrl.sv
// Frame-level write/read controller between an FFT modulus stream and a single-clock FIFO.
// Optional dropped-frame statistics are enabled by defining FFT_FRAME_DROP_STAT_EN.
module fft_modulus_frame_ctrl #(
  parameter int FRAME_LEN   = 1024,
  parameter int DEPTH_WIDTH = 10,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  input  logic                   fifo_wr_full,
  input  logic [DEPTH_WIDTH:0]   fifo_wr_water_level,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_empty,
  input  logic                   frame_req,
  output logic                   frame_rdy,
  output logic                   m_valid,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic                   len_err,
  output logic [15:0]            drop_cnt
);

  localparam int CW = DEPTH_WIDTH + 1;
  localparam logic [CW-1:0] FL    = CW'(FRAME_LEN);
  localparam logic [CW-1:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST}         r_state_e;

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          pending_q, pending_d;
  logic          frame_rdy_q, frame_rdy_d;
  logic          m_valid_q, m_valid_d;
  logic          m_sop_q, m_sop_d;
  logic          m_eop_q, m_eop_d;

  logic [CW-1:0] space;
  logic [CW-1:0] wbeat;
  logic          room;
  logic          wr_en;
  logic          err;
  logic          frame_done;
  logic          launch;

  assign space = DEPTH - fifo_wr_water_level;
  assign room  = (space >= FL);
  assign wbeat = wcnt_q + ONE;

  // Write side: admission is decided once, on the sop beat, for the whole frame.
  always_comb begin
    w_state_d  = w_state_q;
    wcnt_d     = wcnt_q;
    wr_en      = 1'b0;
    err        = 1'b0;
    frame_done = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_valid && s_sop) begin
          wcnt_d = ONE;
          err    = s_eop;
          if (room) begin
            w_state_d = W_STORE;
            wr_en     = 1'b1;
          end else begin
            w_state_d = W_DROP;
          end
        end
      end
      default: begin
        if (s_valid) begin
          wr_en = (w_state_q == W_STORE);
          err   = (s_eop && (wbeat != FL)) || s_sop;
          if (wbeat == FL) begin
            w_state_d  = W_IDLE;
            wcnt_d     = '0;
            frame_done = (w_state_q == W_STORE);
          end else begin
            wcnt_d = wbeat;
          end
        end
      end
    endcase
  end

  assign fifo_wr_en   = wr_en;
  assign fifo_wr_data = s_data;
  assign len_err      = err;

  // Read side and frame bookkeeping; a store and a launch in one cycle cancel out.
  always_comb begin
    launch    = (r_state_q == R_IDLE) && pending_q && frame_rdy_q;
    pending_d = frame_req | (pending_q & ~launch);
    fcnt_d    = fcnt_q;
    if (frame_done && !launch) begin
      fcnt_d = fcnt_q + ONE;
    end else if (!frame_done && launch) begin
      fcnt_d = fcnt_q - ONE;
    end
    frame_rdy_d = (fcnt_d != '0);

    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (launch) begin
          r_state_d = R_BURST;
          rcnt_d    = ONE;
        end
      end
      default: begin
        if (rcnt_q == FL) begin
          r_state_d = R_IDLE;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
    endcase

    m_valid_d = (r_state_q == R_BURST);
    m_sop_d   = (r_state_q == R_BURST) && (rcnt_q == ONE);
    m_eop_d   = (r_state_q == R_BURST) && (rcnt_q == FL);
  end

  assign fifo_rd_en = (r_state_q == R_BURST);
  assign frame_rdy  = frame_rdy_q;
  assign m_valid    = m_valid_q;
  assign m_sop      = m_sop_q;
  assign m_eop      = m_eop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      fcnt_q      <= '0;
      pending_q   <= 1'b0;
      frame_rdy_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      fcnt_q      <= fcnt_d;
      pending_q   <= pending_d;
      frame_rdy_q <= frame_rdy_d;
      m_valid_q   <= m_valid_d;
      m_sop_q     <= m_sop_d;
      m_eop_q     <= m_eop_d;
    end
  end

`ifdef FFT_FRAME_DROP_STAT_EN
  logic        drop_start;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop_start = (w_state_q == W_IDLE) && (w_state_d == W_DROP);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_start && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  // FIFO flag sanity: admission control must keep these from ever firing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fifo_wr_en && fifo_wr_full));
      assert (!(fifo_rd_en && fifo_rd_empty));
    end
  end

endmodule

// File: tb/tb_fft_modulus_frame_ctrl.sv
// Scoreboard bench for fft_modulus_frame_ctrl with a behavioural FIFO model.
module tb_fft_modulus_frame_ctrl;

  localparam int FL  = 1024;
  localparam int DW  = 11;
  localparam int DWD = 32;
`ifdef FFT_FRAME_DROP_STAT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic           clk;
  logic           rst_n;
  logic           s_valid, s_sop, s_eop;
  logic [DWD-1:0] s_data;
  logic           fifo_wr_en;
  logic [DWD-1:0] fifo_wr_data;
  logic           fifo_wr_full;
  logic [DW:0]    fifo_wr_water_level;
  logic           fifo_rd_en;
  logic           fifo_rd_empty;
  logic           frame_req;
  logic           frame_rdy;
  logic           m_valid, m_sop, m_eop;
  logic           len_err;
  logic [15:0]    drop_cnt;

  logic           force_lvl;
  logic [DW:0]    lvl_ovr;
  int             model_cnt;
  logic [DWD-1:0] fq[$];
  logic [1:0]     sb[$];
  int             total, bad;
  int             wr_cnt;

  fft_modulus_frame_ctrl #(.FRAME_LEN(FL), .DEPTH_WIDTH(DW), .DATA_WIDTH(DWD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_data(s_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_wr_water_level(fifo_wr_water_level),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_empty(fifo_rd_empty),
    .frame_req(frame_req), .frame_rdy(frame_rdy),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
    .len_err(len_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_wr_water_level = force_lvl ? lvl_ovr : (DW+1)'(model_cnt);
  assign fifo_wr_full        = (model_cnt >= (1 << DW));
  assign fifo_rd_empty       = (model_cnt == 0);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: cleared by the same reset as the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      model_cnt = 0;
    end else begin
      if (fifo_wr_en) begin
        check("wr_while_full", fifo_wr_full, 0);
        wr_cnt++;
      end
      if (fifo_rd_en) check("rd_while_empty", fifo_rd_empty, 0);
      if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr_en) fq.push_back(fifo_wr_data);
      model_cnt = fq.size();
    end
  end

  // Output monitor: every presented beat must match the next expected sop/eop pair.
  always @(negedge clk) begin
    logic [1:0] e;
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("m_valid_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("m_sop", m_sop, e[1]);
        check("m_eop", m_eop, e[0]);
      end
    end
  end

  task automatic push_burst();
    logic [1:0] e;
    for (int i = 0; i < FL; i++) begin
      e = {(i == 0), (i == FL - 1)};
      sb.push_back(e);
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic send_frame(input int eop_at, input int sop2_at, input int req_at,
                            input bit exp_store, output int n_err, output int err_beat,
                            output int n_mis);
    n_err = 0; err_beat = 0; n_mis = 0;
    for (int i = 1; i <= FL; i++) begin
      s_valid   = 1'b1;
      s_sop     = (i == 1) || (i == sop2_at);
      s_eop     = (i == eop_at);
      s_data    = DWD'(i * 3 + 7);
      frame_req = (i == req_at);
      #2;
      if (len_err) begin
        n_err++;
        if (err_beat == 0) err_beat = i;
      end
      if ((fifo_wr_en !== exp_store) || (exp_store && (fifo_wr_data !== s_data))) n_mis++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; frame_req = 1'b0;
  endtask

  task automatic wait_burst(output int len, output int rdy_at_start);
    int guard;
    len = 0; guard = 0; rdy_at_start = -1;
    @(negedge clk);
    while (!fifo_rd_en && guard < 4 * FL) begin
      @(negedge clk);
      guard++;
    end
    if (fifo_rd_en) rdy_at_start = int'(frame_rdy);
    while (fifo_rd_en && len < 2 * FL) begin
      len++;
      @(negedge clk);
    end
  endtask

  int ne, eb, nm, w0, blen, brdy, guard;

  initial begin
    total = 0; bad = 0; wr_cnt = 0; model_cnt = 0;
    s_valid = 0; s_sop = 0; s_eop = 0; s_data = '0; frame_req = 0;
    force_lvl = 0; lvl_ovr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_frame_rdy", frame_rdy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_fifo_wr_en", fifo_wr_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One clean frame into an empty FIFO
    w0 = wr_cnt;
    send_frame(FL, 0, 0, 1'b1, ne, eb, nm);
    @(negedge clk);
    check("a_frame_rdy", frame_rdy, 1);
    check("a_wr_count", wr_cnt - w0, FL);
    check("a_len_err_pulses", ne, 0);
    check("a_wr_beat_mismatch", nm, 0);

    // Read it back
    push_burst();
    pulse_req();
    wait_burst(blen, brdy);
    check("b_burst_len", blen, FL);
    check("b_frame_rdy_at_launch", brdy, 0);
    @(negedge clk); #1;
    check("b_sb_left", sb.size(), 0);
    check("b_frame_rdy_after", frame_rdy, 0);
    check("b_fifo_level", model_cnt, 0);
    @(posedge clk); #1;

    // Free space one short of a frame: whole frame is dropped
    force_lvl = 1'b1;
    lvl_ovr   = (DW+1)'((1 << DW) - FL + 1);
    w0 = wr_cnt;
    send_frame(FL, 0, 0, 1'b0, ne, eb, nm);
    force_lvl = 1'b0;
    @(negedge clk);
    check("c_drop_cnt", drop_cnt, EXP_DROP);
    check("c_wr_count", wr_cnt - w0, 0);
    check("c_wr_beat_mismatch", nm, 0);
    check("c_len_err_pulses", ne, 0);
    check("c_frame_rdy", frame_rdy, 0);
    @(posedge clk); #1;

    // Stray beats without sop while idle are discarded silently
    w0 = wr_cnt; ne = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_eop = (i == 2); s_data = DWD'(i);
      #2;
      if (len_err || fifo_wr_en) ne++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_eop = 1'b0;
    check("s_stray_activity", ne, 0);
    check("s_wr_count", wr_cnt - w0, 0);

    // Early eop on beat 1000: flagged once, frame still runs to FL and is counted
    w0 = wr_cnt;
    send_frame(1000, 0, 0, 1'b1, ne, eb, nm);
    @(negedge clk);
    check("d_len_err_pulses", ne, 1);
    check("d_len_err_beat", eb, 1000);
    check("d_wr_count", wr_cnt - w0, FL);
    check("d_wr_beat_mismatch", nm, 0);
    check("d_frame_rdy", frame_rdy, 1);
    @(posedge clk); #1;

    // Last stored beat lands on the same edge as a burst launch (level FL: exactly room)
    push_burst();
    send_frame(FL, 0, FL - 1, 1'b1, ne, eb, nm);
    check("e_len_err_pulses", ne, 0);
    check("e_wr_beat_mismatch", nm, 0);
    wait_burst(blen, brdy);
    check("e_burst_len", blen, FL);
    check("e_frame_rdy_at_launch", brdy, 1);
    @(negedge clk); #1;
    check("e_frame_rdy_after", frame_rdy, 1);
    check("e_fifo_level", model_cnt, FL);
    @(posedge clk); #1;

    // Reset in the middle of a burst (beat 500)
    push_burst();
    pulse_req();
    guard = 0;
    while (!fifo_rd_en && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("f_burst_started", fifo_rd_en, 1);
    repeat (499) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("f_rd_en_in_reset", fifo_rd_en, 0);
    check("f_m_valid_in_reset", m_valid, 0);
    check("f_frame_rdy_in_reset", frame_rdy, 0);
    check("f_drop_cnt_in_reset", drop_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First frame after reset, with a stray sop on beat 7
    w0 = wr_cnt;
    send_frame(FL, 7, 0, 1'b1, ne, eb, nm);
    @(negedge clk);
    check("g_len_err_pulses", ne, 1);
    check("g_len_err_beat", eb, 7);
    check("g_wr_count", wr_cnt - w0, FL);
    check("g_wr_beat_mismatch", nm, 0);
    check("g_frame_rdy", frame_rdy, 1);
    check("g_no_stale_burst", fifo_rd_en, 0);
    @(posedge clk); #1;
    push_burst();
    pulse_req();
    wait_burst(blen, brdy);
    check("g_burst_len", blen, FL);
    @(negedge clk); #1;
    check("g_sb_left", sb.size(), 0);
    check("g_frame_rdy_after", frame_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_modulus_frame_ctrl.md
FFT_MODULUS_FRAME_CTRL -- requirements
Module: fft_modulus_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, beats per FFT modulus frame (2 to 2^DEPTH_WIDTH).
REQ-002 SHALL have parameter DEPTH_WIDTH, default 10, FIFO address width (FIFO depth 2^DEPTH_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, modulus sample width.
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock for both FIFO sides; SYN FIFO
- rst_n  in  1  reset, asynchronous, active-low
- s_valid / s_sop / s_eop  in  1 each  modulus stream beat / first / last
- s_data  in  DATA_WIDTH  modulus sample
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- fifo_wr_full  in  1  FIFO full flag
- fifo_wr_water_level  in  DEPTH_WIDTH+1  FIFO fill count
- fifo_rd_en  out  1  FIFO read enable
- fifo_rd_empty  in  1  FIFO empty flag
- frame_req  in  1  consumer pulse requesting one frame
- frame_rdy  out  1  at least one complete frame stored
- m_valid / m_sop / m_eop  out  1 each  read-out beat / first / last
- len_err  out  1  one-cycle pulse on malformed input framing
- drop_cnt  out  16  dropped-frame count (see Configuration)

Function
REQ-005 Write FSM states: W_IDLE, W_STORE, W_DROP.
REQ-006 W_IDLE: on s_valid&s_sop, SHALL go W_STORE if (2^DEPTH_WIDTH - fifo_wr_water_level) >= FRAME_LEN, else W_DROP; the sop beat is written (W_STORE) or discarded (W_DROP) in that cycle.
REQ-007 s_valid without s_sop in W_IDLE SHALL be discarded.
REQ-008 fifo_wr_en SHALL equal s_valid while storing, combinational, fifo_wr_data = s_data; zero-latency passthrough.
REQ-009 Beat counter SHALL count accepted or dropped beats; frame ends on beat FRAME_LEN, returning to W_IDLE regardless of s_eop.
REQ-010 len_err SHALL pulse when s_eop is high on a beat other than FRAME_LEN, or s_sop is high on a beat other than 1 within a frame; framing is not altered.
REQ-011 fifo_wr_en SHALL never assert while fifo_wr_full is high (guaranteed by REQ-006; assertion in bench).
REQ-012 Frame counter (DEPTH_WIDTH+1 bits) SHALL +1 on the final stored beat, -1 on read-burst launch; simultaneous events leave it unchanged.
REQ-013 frame_rdy SHALL be registered, high when frame counter != 0.
REQ-014 Read FSM states: R_IDLE, R_BURST. frame_req is latched into a pending flag; R_IDLE -> R_BURST when pending&frame_rdy, clearing pending.
REQ-015 R_BURST SHALL assert fifo_rd_en exactly FRAME_LEN consecutive cycles, then return to R_IDLE; back-to-back bursts allowed with one R_IDLE cycle between.
REQ-016 m_valid/m_sop/m_eop SHALL be fifo_rd_en and burst first/last beat delayed one cycle (FIFO read latency 1).
REQ-017 frame_req while in R_BURST SHALL set pending; further requests while pending are merged.
REQ-018 fifo_rd_en asserting with fifo_rd_empty high is a design error (bench assertion).

Reset
REQ-019 rst_n low SHALL asynchronously force W_IDLE, R_IDLE, counters 0, pending 0; all registered outputs 0.
REQ-020 Reset mid-frame or mid-burst SHALL abandon it; FIFO is reset by the same reset externally; first post-reset frame starts on next s_sop.
REQ-021 Reset release SHALL be synchronous to clk (deassertion sampled on rising edge).

Configuration
REQ-022 Macro FFT_FRAME_DROP_STAT_EN defined: drop_cnt SHALL +1 per W_IDLE->W_DROP transition, saturating at 16'hFFFF, cleared by reset.
REQ-023 Macro undefined: drop_cnt SHALL be constant 0; no counter logic instantiated.

Verification
REQ-024 FRAME_LEN=1024, empty FIFO, one 1024-beat frame -> 1024 fifo_wr_en, frame_rdy high cycle after last beat, len_err never.
REQ-025 frame_req after frame_rdy -> 1024 fifo_rd_en cycles; m_sop on first, m_eop on 1024th m_valid; frame_rdy drops.
REQ-026 FRAME_LEN=1024, water level 1 at sop -> frame dropped, no fifo_wr_en, drop_cnt=1 (macro defined) / 0 (undefined).
REQ-027 s_eop on beat 1000 -> len_err pulse that cycle; frame still ends at beat 1024 and is counted.
REQ-028 Final stored beat coincides with burst launch, counter 1 -> counter stays 1, frame_rdy stays high.
REQ-029 rst_n low at beat 500 of a burst -> fifo_rd_en, m_valid low immediately; frame_rdy 0; next frame accepted normally.
